sm3_cmprss_ctrl: RTL and testbench

SM3_CMPRSS_CTRL -- requirements
Module: sm3_cmprss_ctrl

---
 rtl/sm3_pkg.sv | 24 ++
 rtl/sm3_cmprss_ctrl_if.sv | 39 +++
 rtl/sm3_cmprss_ceil_comb.sv | 35 +++
 rtl/sm3_cmprss_ctrl.sv | 119 +++++++++++
 tb/tb_sm3_cmprss_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sm3_pkg.sv
// Shared constants and state encoding for the SM3 compression controller.
package sm3_pkg;

  localparam logic [255:0] SM3_IV = {
    32'h7380166F, 32'h4914B2B9, 32'h172442D7, 32'hDA8A0600,
    32'hA96F30BC, 32'h163138AA, 32'hE38DEE4D, 32'hB0FB0E4E
  };

  // Round constant for j=0..15, and the value for j=16, which is
  // rotl(0x7A879D8A, 16), so the register keeps rotating by one per round.
  localparam logic [31:0] SM3_T0  = 32'h79CC4519;
  localparam logic [31:0] SM3_T16 = 32'h9D8A7A87;

  localparam int unsigned SM3_WORDS  = 16;
  localparam int unsigned SM3_ROUNDS = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FINAL = 2'd3
  } sm3_state_t;

endpackage

// File: rtl/sm3_cmprss_ctrl_if.sv
// Message/digest bundle between a word source and the SM3 compression controller.
interface sm3_cmprss_ctrl_if;
  import sm3_pkg::*;

  // A message word transfers on a rising clk edge where msg_vld_i and
  // msg_rdy_o are both high; msg_i and blk_first_i must be stable while
  // msg_vld_i is high, and msg_rdy_o never depends on msg_vld_i.
  logic         msg_vld_i;
  logic         msg_rdy_o;
  logic [31:0]  msg_i;
  logic         blk_first_i;
  logic         busy_o;
  logic         digest_vld_o;
  logic [255:0] digest_o;
  sm3_state_t   state_dbg;

  modport slave (
    input  msg_vld_i,
    input  msg_i,
    input  blk_first_i,
    output msg_rdy_o,
    output busy_o,
    output digest_vld_o,
    output digest_o,
    output state_dbg
  );

  modport master (
    output msg_vld_i,
    output msg_i,
    output blk_first_i,
    input  msg_rdy_o,
    input  busy_o,
    input  digest_vld_o,
    input  digest_o,
    input  state_dbg
  );

endinterface

// File: rtl/sm3_cmprss_ceil_comb.sv
// One combinational SM3 compression round: {A..H} in, next {A..H} out.
module sm3_cmprss_ceil_comb (
  input  logic [255:0] abcdefgh,
  input  logic [31:0]  wj,
  input  logic [31:0]  wjj,
  input  logic [31:0]  tj,
  input  logic         round_lt16,
  output logic [255:0] nxt
);

  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] p0(input logic [31:0] x);
    return x ^ rotl(x, 9) ^ rotl(x, 17);
  endfunction

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] a12, ss1, ss2, ff, gg, tt1, tt2;

  // tj arrives already rotated by j mod 32, so no rotation is applied here.
  always_comb begin
    {a, b, c, d, e, f, g, h} = abcdefgh;
    a12 = rotl(a, 12);
    ss1 = rotl(a12 + e + tj, 7);
    ss2 = ss1 ^ a12;
    ff  = round_lt16 ? (a ^ b ^ c) : ((a & b) | (a & c) | (b & c));
    gg  = round_lt16 ? (e ^ f ^ g) : ((e & f) | (~e & g));
    tt1 = ff + d + ss2 + wjj;
    tt2 = gg + h + ss1 + wj;
    nxt = {tt1, a, rotl(b, 9), c, p0(tt2), e, rotl(f, 19), g};
  end

endmodule

// File: rtl/sm3_cmprss_ctrl.sv
// SM3 compression controller: loads 16 words, runs 64 rounds one per cycle,
// then folds the result into the chaining value presented on digest_o.
module sm3_cmprss_ctrl
  import sm3_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  sm3_cmprss_ctrl_if.slave bus
);

  sm3_state_t   state;
  sm3_state_t   state_nxt;
  logic [5:0]   j;
  logic [31:0]  w [SM3_WORDS];
  logic [255:0] v;
  logic [31:0]  tj;
  logic         blk_first;
  logic [255:0] digest_q;

  logic         rdy;
  logic         hs;
  logic         final_pulse;
  logic [31:0]  w_new;
  logic [255:0] round_out;
  logic [255:0] digest_src;
  logic [255:0] digest_new;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rotl(x, 15) ^ rotl(x, 23);
  endfunction

  assign rdy         = !rst && (state == ST_IDLE || state == ST_LOAD);
  assign hs          = rdy && bus.msg_vld_i;
  assign final_pulse = !rst && (state == ST_FINAL);

  // Next word of the expansion, appended at the top of the sliding window.
  assign w_new      = p1(w[0] ^ w[7] ^ rotl(w[13], 15)) ^ rotl(w[3], 7) ^ w[10];
  assign digest_src = blk_first ? SM3_IV : digest_q;
  assign digest_new = v ^ digest_src;

  sm3_cmprss_ceil_comb u_round (
    .abcdefgh   (v),
    .wj         (w[0]),
    .wjj        (w[0] ^ w[4]),
    .tj         (tj),
    .round_lt16 (j < 6'd16),
    .nxt        (round_out)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (hs) state_nxt = ST_LOAD;
      ST_LOAD:  if (hs && j == 6'd15) state_nxt = ST_RUN;
      ST_RUN:   if (j == 6'd63) state_nxt = ST_FINAL;
      ST_FINAL: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // j doubles as the word index while loading, then as the round counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      j         <= '0;
      v         <= '0;
      tj        <= '0;
      blk_first <= 1'b0;
      digest_q  <= SM3_IV;
      for (int k = 0; k < SM3_WORDS; k++) w[k] <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        ST_IDLE: begin
          if (hs) begin
            w[0]      <= bus.msg_i;
            blk_first <= bus.blk_first_i;
            j         <= 6'd1;
          end
        end
        ST_LOAD: begin
          if (hs) begin
            w[j[3:0]] <= bus.msg_i;
            if (j == 6'd15) begin
              j  <= '0;
              tj <= SM3_T0;
              v  <= digest_src;
            end else begin
              j <= j + 6'd1;
            end
          end
        end
        ST_RUN: begin
          v <= round_out;
          for (int k = 0; k < SM3_WORDS - 1; k++) w[k] <= w[k+1];
          w[SM3_WORDS-1] <= w_new;
          j  <= j + 6'd1;
          tj <= (j == 6'd15) ? SM3_T16 : rotl(tj, 1);
        end
        ST_FINAL: begin
          digest_q <= digest_new;
        end
        default: ;
      endcase
    end
  end

  // During FINAL the freshly folded value is shown so it lines up with the pulse.
  assign bus.msg_rdy_o    = rdy;
  assign bus.busy_o       = !rst && (state != ST_IDLE);
  assign bus.digest_vld_o = final_pulse;
  assign bus.digest_o     = final_pulse ? digest_new : digest_q;
  assign bus.state_dbg    = state;

endmodule

// File: tb/tb_sm3_cmprss_ctrl.sv
// Bench for sm3_cmprss_ctrl: directed SM3 vectors plus random blocks against a reference compression model.
module tb_sm3_cmprss_ctrl;
  import sm3_pkg::*;

  typedef logic [31:0] blk_t [16];

  localparam logic [255:0] TB_IV = {
    32'h7380166F, 32'h4914B2B9, 32'h172442D7, 32'hDA8A0600,
    32'hA96F30BC, 32'h163138AA, 32'hE38DEE4D, 32'hB0FB0E4E
  };
  localparam logic [255:0] ABC_DIGEST = {
    32'h66C7F0F4, 32'h62EEEDD9, 32'hD1F2D46B, 32'hDC10E4E2,
    32'h4167C487, 32'h5CF2F7A2, 32'h297DA02B, 32'h8F4BA8E0
  };
  localparam logic [255:0] ABCD16_DIGEST = {
    32'hDEBE9FF9, 32'h2275B8A1, 32'h38604889, 32'hC18E5A4D,
    32'h6FDB70E5, 32'h387E5765, 32'h293DCBA3, 32'h9C0C5732
  };

  logic clk = 1'b0;
  logic rst;

  sm3_cmprss_ctrl_if bus ();

  sm3_cmprss_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int pulse_cnt = 0;
  int stable_err = 0;
  logic [255:0] last_digest;
  logic [255:0] model_v;
  logic [255:0] exp_q [$];

  // Pulse counter and digest-hold monitor.
  always @(negedge clk) begin
    if (bus.digest_vld_o === 1'b1) pulse_cnt++;
    if (rst) last_digest = TB_IV;
    else if (bus.digest_vld_o === 1'b1) last_digest = bus.digest_o;
    else if (bus.digest_o !== last_digest) stable_err++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    int m;
    m = n % 32;
    if (m == 0) return x;
    return (x << m) | (x >> (32 - m));
  endfunction

  function automatic logic [31:0] p0f(input logic [31:0] x);
    return x ^ rl(x, 9) ^ rl(x, 17);
  endfunction

  function automatic logic [31:0] p1f(input logic [31:0] x);
    return x ^ rl(x, 15) ^ rl(x, 23);
  endfunction

  function automatic logic [255:0] ref_compress(input logic [255:0] vin, input blk_t b);
    logic [31:0] w [68];
    logic [31:0] w1 [64];
    logic [31:0] a, bb, c, d, e, f, g, h, t, ss1, ss2, ff, gg, tt1, tt2;
    for (int k = 0; k < 16; k++) w[k] = b[k];
    for (int k = 16; k < 68; k++)
      w[k] = p1f(w[k-16] ^ w[k-9] ^ rl(w[k-3], 15)) ^ rl(w[k-13], 7) ^ w[k-6];
    for (int k = 0; k < 64; k++) w1[k] = w[k] ^ w[k+4];
    {a, bb, c, d, e, f, g, h} = vin;
    for (int k = 0; k < 64; k++) begin
      t   = (k < 16) ? 32'h79CC4519 : 32'h7A879D8A;
      ss1 = rl(rl(a, 12) + e + rl(t, k), 7);
      ss2 = ss1 ^ rl(a, 12);
      ff  = (k < 16) ? (a ^ bb ^ c) : ((a & bb) | (a & c) | (bb & c));
      gg  = (k < 16) ? (e ^ f ^ g) : ((e & f) | (~e & g));
      tt1 = ff + d + ss2 + w1[k];
      tt2 = gg + h + ss1 + w[k];
      d = c; c = rl(bb, 9); bb = a; a = tt1;
      h = g; g = rl(f, 19); f = e; e = p0f(tt2);
    end
    return {a, bb, c, d, e, f, g, h} ^ vin;
  endfunction

  task automatic model_apply(input blk_t b, input bit first);
    model_v = ref_compress(first ? TB_IV : model_v, b);
    exp_q.push_back(model_v);
  endtask

  function automatic blk_t abc_blk();
    blk_t b;
    for (int k = 0; k < 16; k++) b[k] = 32'h0;
    b[0]  = 32'h61626380;
    b[15] = 32'h00000018;
    return b;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_block(input blk_t b, input bit first, input int gap_pct,
                            input bit hold_vld, output bit ok);
    bit done;
    ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
        bus.msg_vld_i = 1'b0;
        bus.msg_i     = $urandom;
        @(posedge clk); #1;
      end
      bus.msg_vld_i   = 1'b1;
      bus.msg_i       = b[i];
      bus.blk_first_i = (i == 0) ? first : 1'($urandom_range(1));
      done = 1'b0;
      for (int t = 0; t < 200 && !done; t++) begin
        @(negedge clk);
        if (bus.msg_rdy_o === 1'b1) done = 1'b1;
        @(posedge clk); #1;
      end
      if (!done) ok = 1'b0;
    end
    if (hold_vld) begin
      bus.msg_vld_i = 1'b1;
      bus.msg_i     = $urandom;
    end else begin
      bus.msg_vld_i = 1'b0;
    end
  endtask

  task automatic wait_digest(input int budget, output logic [255:0] d, output int cyc,
                             output bit seen);
    seen = 1'b0;
    cyc  = -1;
    d    = 'x;
    for (int k = 1; k <= budget && !seen; k++) begin
      @(negedge clk);
      if (bus.digest_vld_o === 1'b1) begin
        d    = bus.digest_o;
        cyc  = k;
        seen = 1'b1;
        bus.msg_vld_i = 1'b0;
      end
    end
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_total++; if (bus.msg_rdy_o !== 1'b0) $display("FAIL reset_rdy: got %b expected 0", bus.msg_rdy_o); else n_pass++;
    n_total++; if (bus.busy_o !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy_o); else n_pass++;
    n_total++; if (bus.digest_vld_o !== 1'b0) $display("FAIL reset_vld: got %b expected 0", bus.digest_vld_o); else n_pass++;
    n_total++; if (bus.digest_o !== TB_IV) $display("FAIL reset_digest: got %h expected %h", bus.digest_o, TB_IV); else n_pass++;
    n_total++; if (bus.state_dbg !== ST_IDLE) $display("FAIL reset_state: got %0d expected %0d", bus.state_dbg, ST_IDLE); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_total++; if (bus.msg_rdy_o !== 1'b1) $display("FAIL post_reset_rdy: got %b expected 1", bus.msg_rdy_o); else n_pass++;
    n_total++; if (bus.busy_o !== 1'b0) $display("FAIL post_reset_busy: got %b expected 0", bus.busy_o); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_abc();
    logic [255:0] d, e;
    int cyc, p0;
    bit seen, ok;
    p0 = pulse_cnt;
    model_apply(abc_blk(), 1'b1);
    send_block(abc_blk(), 1'b1, 0, 1'b0, ok);
    n_total++; if (!ok) $display("FAIL abc_accept: got accepted=0 expected 1"); else n_pass++;
    wait_digest(100, d, cyc, seen);
    e = exp_q.pop_front();
    n_total++; if (seen !== 1'b1) $display("FAIL abc_pulse: got seen=%b expected 1", seen); else n_pass++;
    n_total++; if (d !== ABC_DIGEST) $display("FAIL abc_digest: got %h expected %h", d, ABC_DIGEST); else n_pass++;
    n_total++; if (d !== e) $display("FAIL abc_model: got %h expected %h", d, e); else n_pass++;
    n_total++; if (pulse_cnt - p0 !== 1) $display("FAIL abc_pulse_count: got %0d expected 1", pulse_cnt - p0); else n_pass++;
  endtask

  task automatic test_timing();
    blk_t b;
    logic [255:0] d, e;
    int pulse_at, extra, rdy_bad, busy_bad;
    bit ok;
    for (int k = 0; k < 16; k++) b[k] = $urandom;
    model_apply(b, 1'b1);
    send_block(b, 1'b1, 0, 1'b0, ok);
    pulse_at = -1; extra = 0; rdy_bad = 0; busy_bad = 0; d = 'x;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (bus.digest_vld_o === 1'b1) begin
        if (pulse_at < 0) begin pulse_at = k; d = bus.digest_o; end
        else extra++;
      end
      if (k <= 65 && bus.msg_rdy_o !== 1'b0) rdy_bad++;
      if (k <= 65 && bus.busy_o !== 1'b1) busy_bad++;
    end
    e = exp_q.pop_front();
    n_total++; if (pulse_at !== 65) $display("FAIL timing_latency: got %0d expected 65", pulse_at); else n_pass++;
    n_total++; if (extra !== 0) $display("FAIL timing_extra_pulses: got %0d expected 0", extra); else n_pass++;
    n_total++; if (rdy_bad !== 0) $display("FAIL timing_rdy_low: got %0d high cycles expected 0", rdy_bad); else n_pass++;
    n_total++; if (busy_bad !== 0) $display("FAIL timing_busy: got %0d low cycles expected 0", busy_bad); else n_pass++;
    n_total++; if (d !== e) $display("FAIL timing_digest: got %h expected %h", d, e); else n_pass++;
    n_total++; if (bus.msg_rdy_o !== 1'b1 || bus.busy_o !== 1'b0)
      $display("FAIL timing_back_idle: got rdy=%b busy=%b expected rdy=1 busy=0", bus.msg_rdy_o, bus.busy_o); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_chain();
    blk_t b1, b2;
    logic [255:0] d, e;
    int cyc, p0;
    bit seen, ok;
    for (int k = 0; k < 16; k++) begin b1[k] = 32'h61626364; b2[k] = 32'h0; end
    b2[0]  = 32'h80000000;
    b2[15] = 32'h00000200;
    p0 = pulse_cnt;
    model_apply(b1, 1'b1);
    send_block(b1, 1'b1, 0, 1'b0, ok);
    wait_digest(100, d, cyc, seen);
    e = exp_q.pop_front();
    n_total++; if (d !== e) $display("FAIL chain_blk1: got %h expected %h", d, e); else n_pass++;
    model_apply(b2, 1'b0);
    send_block(b2, 1'b0, 0, 1'b0, ok);
    wait_digest(100, d, cyc, seen);
    e = exp_q.pop_front();
    n_total++; if (d !== ABCD16_DIGEST) $display("FAIL chain_digest: got %h expected %h", d, ABCD16_DIGEST); else n_pass++;
    n_total++; if (d !== e) $display("FAIL chain_model: got %h expected %h", d, e); else n_pass++;
    n_total++; if (pulse_cnt - p0 !== 2) $display("FAIL chain_pulse_count: got %0d expected 2", pulse_cnt - p0); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [255:0] d, e;
    int cyc;
    bit seen, ok;
    for (int r = 0; r < 2; r++) begin
      model_apply(abc_blk(), 1'b1);
      send_block(abc_blk(), 1'b1, 40 + 20 * r, 1'b1, ok);
      n_total++; if (!ok) $display("FAIL bp_accept: got accepted=0 expected 1"); else n_pass++;
      wait_digest(100, d, cyc, seen);
      e = exp_q.pop_front();
      n_total++; if (d !== ABC_DIGEST) $display("FAIL bp_digest: got %h expected %h", d, ABC_DIGEST); else n_pass++;
      n_total++; if (d !== e) $display("FAIL bp_model: got %h expected %h", d, e); else n_pass++;
      repeat (3) @(posedge clk);
      #1;
      n_total++; if (bus.state_dbg !== ST_IDLE || bus.busy_o !== 1'b0)
        $display("FAIL bp_idle: got state=%0d busy=%b expected state=%0d busy=0", bus.state_dbg, bus.busy_o, ST_IDLE); else n_pass++;
    end
  endtask

  task automatic test_reset_abort();
    logic [255:0] d, e;
    int cyc, p0;
    bit seen, ok;
    time t0;
    p0 = pulse_cnt;
    send_block(abc_blk(), 1'b1, 0, 1'b0, ok);
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    n_total++; if (bus.msg_rdy_o !== 1'b0) $display("FAIL abort_rdy_in_reset: got %b expected 0", bus.msg_rdy_o); else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++; if (bus.digest_o !== TB_IV) $display("FAIL abort_digest_iv: got %h expected %h", bus.digest_o, TB_IV); else n_pass++;
    n_total++; if (bus.state_dbg !== ST_IDLE) $display("FAIL abort_state: got %0d expected %0d", bus.state_dbg, ST_IDLE); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    model_v = TB_IV;
    model_apply(abc_blk(), 1'b0);
    t0 = $time;
    send_block(abc_blk(), 1'b0, 0, 1'b0, ok);
    n_total++; if ($time - t0 !== 160) $display("FAIL abort_first_hs: got %0t expected 160", $time - t0); else n_pass++;
    wait_digest(100, d, cyc, seen);
    e = exp_q.pop_front();
    n_total++; if (d !== ABC_DIGEST) $display("FAIL abort_rechain: got %h expected %h", d, ABC_DIGEST); else n_pass++;
    n_total++; if (d !== e) $display("FAIL abort_model: got %h expected %h", d, e); else n_pass++;
    n_total++; if (pulse_cnt - p0 !== 1) $display("FAIL abort_pulse_count: got %0d expected 1", pulse_cnt - p0); else n_pass++;
  endtask

  task automatic test_rerun();
    logic [255:0] d, e;
    int cyc, s0;
    bit seen, ok;
    s0 = stable_err;
    for (int r = 0; r < 2; r++) begin
      model_apply(abc_blk(), 1'b1);
      send_block(abc_blk(), 1'b1, 0, 1'b0, ok);
      wait_digest(100, d, cyc, seen);
      e = exp_q.pop_front();
      n_total++; if (d !== ABC_DIGEST) $display("FAIL rerun_digest: got %h expected %h", d, ABC_DIGEST); else n_pass++;
      n_total++; if (d !== e) $display("FAIL rerun_model: got %h expected %h", d, e); else n_pass++;
    end
    n_total++; if (stable_err - s0 !== 0) $display("FAIL rerun_hold: got %0d changes expected 0", stable_err - s0); else n_pass++;
  endtask

  task automatic test_random();
    blk_t b;
    logic [255:0] d, e;
    int cyc;
    bit seen, ok, first;
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 16; k++) b[k] = $urandom;
      first = 1'($urandom_range(1));
      model_apply(b, first);
      send_block(b, first, int'($urandom_range(50)), 1'($urandom_range(1)), ok);
      wait_digest(100, d, cyc, seen);
      e = exp_q.pop_front();
      n_total++; if (d !== e) $display("FAIL random_blk%0d: got %h expected %h", r, d, e); else n_pass++;
    end
    n_total++; if (stable_err !== 0) $display("FAIL digest_hold_total: got %0d changes expected 0", stable_err); else n_pass++;
  endtask

  initial begin
    rst             = 1'b1;
    bus.msg_vld_i   = 1'b0;
    bus.msg_i       = '0;
    bus.blk_first_i = 1'b0;
    model_v         = TB_IV;
    test_reset();
    test_abc();
    test_timing();
    test_chain();
    test_backpressure();
    test_reset_abort();
    test_rerun();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
